// File: rtl/rrat_retire_if.sv
// Commit/freelist bundle for the retirement RAT.
// master: ROB + Freelist side; slave: rrat_retire.
//   commit_valid/rd/pd -> ; commit_ready <-
//   free_full -> ; free_enq/free_pd <- ; recover_free_list_head <-
//   rrat_map <- (entry i at [i*PW +: PW])
interface rrat_retire_if #(
    parameter int ARCH_REG_NUM = 32,
    parameter int P_REG_NUM    = 64,
    parameter int FL_DEPTH     = 32
);
    localparam int PW = $clog2(P_REG_NUM);
    localparam int HW = $clog2(FL_DEPTH) + 1;

    logic                      commit_valid;
    logic [4:0]                commit_rd;
    logic [PW-1:0]             commit_pd;
    logic                      commit_ready;
    logic                      free_full;
    logic                      free_enq;
    logic [PW-1:0]             free_pd;
    logic [HW-1:0]             recover_free_list_head;
    logic [ARCH_REG_NUM*PW-1:0] rrat_map;

    modport master (
        output commit_valid, commit_rd, commit_pd, free_full,
        input  commit_ready, free_enq, free_pd,
        input  recover_free_list_head, rrat_map
    );

    modport slave (
        input  commit_valid, commit_rd, commit_pd, free_full,
        output commit_ready, free_enq, free_pd,
        output recover_free_list_head, rrat_map
    );
endinterface

// File: rtl/rrat_retire.sv
// Retirement RAT: records committed arch->phys maps, frees the
// previous mapping into the Freelist, tracks committed FL head.
// Ports: clk, rst (async, active-high), rr (rrat_retire_if.slave).
module rrat_retire #(
    parameter int ARCH_REG_NUM = 32,
    parameter int P_REG_NUM    = 64,
    parameter int FL_DEPTH     = 32
) (
    input  logic clk,
    input  logic rst,
    rrat_retire_if.slave rr
);
    localparam int PW = $clog2(P_REG_NUM);
    localparam int HW = $clog2(FL_DEPTH) + 1;
    localparam int AW = $clog2(ARCH_REG_NUM);

    logic [PW-1:0] r_map [ARCH_REG_NUM];
    logic          r_enq;
    logic [PW-1:0] r_pd;
    logic [HW-1:0] r_head;

    logic          w_ready;
    logic          w_fire;
    logic          w_wr;
    logic [AW-1:0] w_rd;

    assign w_ready = ~rr.free_full;
    assign w_fire  = rr.commit_valid & w_ready;
    assign w_rd    = AW'(rr.commit_rd);
    // x0 is never renamed, so a commit to it only retires.
    assign w_wr    = w_fire & (w_rd != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ARCH_REG_NUM; i++)
                r_map[i] <= PW'(i);
            r_enq  <= 1'b0;
            r_pd   <= '0;
            // Freelist resets with all FL_DEPTH entries free.
            r_head <= {1'b1, {(HW-1){1'b0}}};
        end else begin
            r_enq <= w_wr;
            if (w_wr) begin
                r_pd        <= r_map[w_rd];
                r_map[w_rd] <= rr.commit_pd;
                r_head      <= r_head + HW'(1);
            end
        end
    end

    assign rr.commit_ready = w_ready;
    assign rr.free_enq     = r_enq;
    assign rr.free_pd      = r_pd;

    // Bypass the in-flight commit so a coincident flush sees it.
    assign rr.recover_free_list_head = r_head + HW'(w_wr);

    always_comb begin
        rr.rrat_map = '0;
        for (int i = 0; i < ARCH_REG_NUM; i++) begin
            if (w_wr && (w_rd == AW'(i)))
                rr.rrat_map[i*PW +: PW] = rr.commit_pd;
            else
                rr.rrat_map[i*PW +: PW] = r_map[i];
        end
    end
endmodule

// File: tb/tb_rrat_retire.sv
// Randomised + directed bench for rrat_retire against
// an array/modular-arithmetic reference model.
module tb_rrat_retire;
    localparam int NA = 32;
    localparam int PW = 6;
    localparam int HM = 64;

    logic clk;
    logic rst;

    rrat_retire_if #(.ARCH_REG_NUM(32), .P_REG_NUM(64), .FL_DEPTH(32)) rr ();

    rrat_retire #(.ARCH_REG_NUM(32), .P_REG_NUM(64), .FL_DEPTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .rr  (rr.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk;
    int n_fail;

    int m_map [NA];
    int m_head;
    int m_enq;
    int m_pd;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int ment(input int i);
        return int'(rr.rrat_map[i*PW +: PW]);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NA; i++) m_map[i] = i;
        m_head = 32;
        m_enq  = 0;
        m_pd   = 0;
    endtask

    task automatic check_state(input string tag);
        check({tag, ".enq"}, int'(rr.free_enq), m_enq);
        check({tag, ".pd"}, int'(rr.free_pd), m_pd);
        check({tag, ".head"}, int'(rr.recover_free_list_head), m_head);
        for (int i = 0; i < NA; i++)
            check($sformatf("%s.map%0d", tag, i), ment(i), m_map[i]);
    endtask

    // One commit cycle: drive at negedge, check bypass paths,
    // then check registered results just after the edge.
    task automatic do_cycle(input string tag, input bit v,
                            input int rd, input int pd, input bit full);
        bit wr;
        @(negedge clk);
        rr.commit_valid = v;
        rr.commit_rd    = 5'(rd);
        rr.commit_pd    = 6'(pd);
        rr.free_full    = full;
        #1;
        wr = v && !full && rd != 0;
        check({tag, ".ready"}, int'(rr.commit_ready), int'(!full));
        check({tag, ".byhead"}, int'(rr.recover_free_list_head),
              (m_head + int'(wr)) % HM);
        check({tag, ".bymap"}, ment(rd), wr ? pd : m_map[rd]);
        if (wr) begin
            m_pd      = m_map[rd];
            m_map[rd] = pd;
            m_head    = (m_head + 1) % HM;
        end
        m_enq = int'(wr);
        @(posedge clk);
        #1;
        rr.commit_valid = 1'b0;
        rr.free_full    = 1'b0;
        #1;
        check_state(tag);
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rr.commit_valid = 1'b0;
        rr.commit_rd    = '0;
        rr.commit_pd    = '0;
        rr.free_full    = 1'b0;
        rst = 1'b1;
        model_reset();
        #12;
        check_state("rst");
        @(negedge clk);
        rst = 1'b0;

        do_cycle("t2", 1, 5, 40, 0);
        check("t2.enq1", int'(rr.free_enq), 1);
        check("t2.pd5", int'(rr.free_pd), 5);

        do_cycle("t3", 1, 5, 41, 0);
        check("t3.pd40", int'(rr.free_pd), 40);
        check("t3.map5", ment(5), 41);

        do_cycle("t4", 1, 0, 33, 0);
        check("t4.enq0", int'(rr.free_enq), 0);

        @(negedge clk);
        rst = 1'b1;
        model_reset();
        #1;
        rst = 1'b0;
        for (int k = 0; k < 64; k++)
            do_cycle("t5w", 1, 1 + (k % 31), k, 0);
        check("t5.wrap", int'(rr.recover_free_list_head), 32);
        @(negedge clk);
        rr.commit_valid = 1'b1;
        rr.commit_rd    = 5'd3;
        rr.commit_pd    = 6'd50;
        #1;
        check("t5.bymap3", ment(3), 50);
        check("t5.byhead", int'(rr.recover_free_list_head), 33);
        rr.commit_valid = 1'b0;

        do_cycle("t6f", 1, 7, 60, 1);
        check("t6.noenq", int'(rr.free_enq), 0);

        do_cycle("t6c", 1, 9, 61, 0);
        check("t6.enq", int'(rr.free_enq), 1);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check_state("t6rst");
        @(negedge clk);
        rst = 1'b0;

        for (int n = 0; n < 300; n++) begin
            do_cycle("rnd", $urandom_range(0, 3) != 0,
                     int'($urandom_range(0, 31)),
                     int'($urandom_range(0, 63)),
                     $urandom_range(0, 9) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
